// File: rtl/sqrt2_arb.sv
// rtl/sqrt2_arb.sv - two-requester round-robin arbiter sharing one sqrt2 unit over a bidirectional bus
module sqrt2_arb #(
    parameter int TIMEOUT     = 100,
    parameter int LOAD_CYCLES = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [15:0] rsp0_data,
    output logic [3:0]  rsp0_flags,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [15:0] rsp1_data,
    output logic [3:0]  rsp1_flags,
    inout  wire  [15:0] sq_io_data,
    output logic        sq_enable,
    input  logic        sq_result,
    input  logic        sq_is_nan,
    input  logic        sq_is_pinf,
    input  logic        sq_is_ninf,
    output logic        busy
);
    localparam int WW   = $clog2(TIMEOUT + 1);
    localparam int PMAX = (LOAD_CYCLES > GAP_CYCLES) ? LOAD_CYCLES : GAP_CYCLES;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam logic [PW-1:0] LOAD_LAST = PW'(LOAD_CYCLES - 1);
    localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, HOLD, GAP, RESP} state_t;

    state_t        state, state_nxt;
    logic          ptr, grant, grant_id, accept, timed_out, rsp_ready_sel;
    logic [15:0]   operand, cap_data;
    logic [3:0]    cap_flags;
    logic [PW-1:0] phase_cnt;
    logic [WW-1:0] wait_cnt;

    // The unit's bus is only ours while loading; reset forces IDLE, so it floats then too.
    assign sq_io_data = (state == LOAD) ? operand : 16'hzzzz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        grant         = (req0_valid && req1_valid) ? ptr : req1_valid;
        accept        = (state == IDLE) && (req0_valid || req1_valid);
        timed_out     = (wait_cnt == WAIT_LAST);
        rsp_ready_sel = grant_id ? rsp1_ready : rsp0_ready;
        state_nxt     = state;
        req0_ready    = rst_n && accept && !grant;
        req1_ready    = rst_n && accept && grant;
        sq_enable     = (state == LOAD) || (state == WAIT) || (state == HOLD);
        busy          = (state != IDLE);
        rsp0_valid    = (state == RESP) && !grant_id;
        rsp1_valid    = (state == RESP) && grant_id;
        case (state)
            IDLE: if (accept) state_nxt = LOAD;
            LOAD: if (phase_cnt == LOAD_LAST) state_nxt = WAIT;
            WAIT: if (sq_result || timed_out) state_nxt = HOLD;
            HOLD: state_nxt = GAP;
            GAP:  if (phase_cnt == GAP_LAST) state_nxt = RESP;
            RESP: if (rsp_ready_sel) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= 1'b0;
            grant_id   <= 1'b0;
            operand    <= '0;
            phase_cnt  <= '0;
            wait_cnt   <= '0;
            cap_data   <= '0;
            cap_flags  <= '0;
            rsp0_data  <= '0;
            rsp0_flags <= '0;
            rsp1_data  <= '0;
            rsp1_flags <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    operand   <= grant ? req1_data : req0_data;
                    grant_id  <= grant;
                    ptr       <= ~grant;
                    phase_cnt <= '0;
                end
                LOAD: begin
                    wait_cnt <= '0;
                    if (phase_cnt == LOAD_LAST) phase_cnt <= '0;
                    else                        phase_cnt <= phase_cnt + 1'b1;
                end
                // A result arriving on the last allowed edge still beats the timeout.
                WAIT: begin
                    if (sq_result) begin
                        cap_data  <= sq_io_data;
                        cap_flags <= {1'b0, sq_is_ninf, sq_is_pinf, sq_is_nan};
                    end else if (timed_out) begin
                        cap_data  <= 16'hFE00;
                        cap_flags <= 4'b1001;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HOLD: phase_cnt <= '0;
                // Response registers change only as the new response is presented.
                GAP: begin
                    phase_cnt <= phase_cnt + 1'b1;
                    if (phase_cnt == GAP_LAST) begin
                        if (grant_id) begin
                            rsp1_data  <= cap_data;
                            rsp1_flags <= cap_flags;
                        end else begin
                            rsp0_data  <= cap_data;
                            rsp0_flags <= cap_flags;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt2_arb.sv
// tb/tb_sqrt2_arb.sv - scoreboard bench for sqrt2_arb with a behavioural sqrt2 unit
module tb_sqrt2_arb;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [15:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, sq_enable, busy;
    logic [15:0] rsp0_data, rsp1_data;
    logic [3:0]  rsp0_flags, rsp1_flags;
    logic        sq_result = 1'b0, sq_is_nan = 1'b0, sq_is_pinf = 1'b0, sq_is_ninf = 1'b0;
    wire  [15:0] sq_io_data;

    logic        mock_drive = 1'b0, tb_drive = 1'b0, drv_en;
    logic [15:0] mock_data = '0, mock_op = '0, drv_val;
    int          mock_lat = 1, en_cnt = 0, cyc = 0, n_checks = 0, n_fail = 0;
    bit          mock_never = 1'b0;

    typedef struct {int id; logic [15:0] data; logic [3:0] flags; int lat;} exp_t;
    exp_t sb[$];
    int   acc_q[$];

    always_comb begin
        drv_en  = mock_drive || tb_drive;
        drv_val = mock_drive ? mock_data : 16'h0000;
    end
    assign sq_io_data = drv_en ? drv_val : 16'hzzzz;

    sqrt2_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_flags(rsp1_flags),
        .sq_io_data(sq_io_data), .sq_enable(sq_enable), .sq_result(sq_result),
        .sq_is_nan(sq_is_nan), .sq_is_pinf(sq_is_pinf), .sq_is_ninf(sq_is_ninf), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {ninf, pinf, nan, data} returned by the modelled sqrt2 unit
    function automatic logic [18:0] sqrt_ref(input logic [15:0] op);
        case (op)
            16'h3C00: return {3'b000, 16'h3C00};
            16'h4400: return {3'b000, 16'h4000};
            16'h4C00: return {3'b000, 16'h4400};
            16'h7C00: return {3'b010, 16'h7C00};
            default:  return {3'b001, 16'hFE00};
        endcase
    endfunction

    // Enable cycles 1..2 are LOAD; the result appears before the mock_lat-th WAIT edge.
    always @(negedge clk) begin
        if (sq_enable) begin
            en_cnt = en_cnt + 1;
            if (en_cnt == 1) mock_op = sq_io_data;
            if (!mock_never && en_cnt == 2 + mock_lat) begin
                {sq_is_ninf, sq_is_pinf, sq_is_nan, mock_data} = sqrt_ref(mock_op);
                mock_drive = 1'b1;
                sq_result  = 1'b1;
            end
        end else begin
            en_cnt = 0; mock_drive = 1'b0; sq_result = 1'b0;
            sq_is_nan = 1'b0; sq_is_pinf = 1'b0; sq_is_ninf = 1'b0;
        end
    end

    task automatic monitor();
        logic pv0 = 1'b0, pv1 = 1'b0;
        exp_t e;
        int   a, got_id;
        forever begin
            @(negedge clk);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_q.push_back(cyc + 1);
            if ((rsp0_valid && !pv0) || (rsp1_valid && !pv1)) begin
                n_checks++;
                if (sb.size() == 0 || acc_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rsp: rsp0_valid=%b rsp1_valid=%b with nothing pending", rsp0_valid, rsp1_valid);
                end else begin
                    e = sb.pop_front();
                    a = acc_q.pop_front();
                    got_id = rsp1_valid ? 1 : 0;
                    n_checks++;
                    if (got_id !== e.id) begin n_fail++; $display("FAIL rsp_id: got %0d expected %0d", got_id, e.id); end
                    n_checks++;
                    if ((got_id ? rsp1_data : rsp0_data) !== e.data) begin
                        n_fail++; $display("FAIL rsp_data: got %h expected %h", got_id ? rsp1_data : rsp0_data, e.data);
                    end
                    n_checks++;
                    if ((got_id ? rsp1_flags : rsp0_flags) !== e.flags) begin
                        n_fail++; $display("FAIL rsp_flags: got %b expected %b", got_id ? rsp1_flags : rsp0_flags, e.flags);
                    end
                    n_checks++;
                    if (cyc - a !== e.lat) begin n_fail++; $display("FAIL rsp_latency: got %0d expected %0d", cyc - a, e.lat); end
                end
            end
            pv0 = rsp0_valid;
            pv1 = rsp1_valid;
        end
    endtask

    task automatic push_exp(input int id, input logic [15:0] d, input logic [3:0] f, input int lat);
        exp_t e;
        e.id = id; e.data = d; e.flags = f; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic issue(input int id, input logic [15:0] d, input logic [15:0] ed,
                         input logic [3:0] ef, input int lat, input bit push);
        int t;
        if (push) push_exp(id, ed, ef, lat);
        @(posedge clk); #1;
        if (id == 0) begin req0_data = d; req0_valid = 1'b1; end
        else         begin req1_data = d; req1_valid = 1'b1; end
        for (t = 0; t < 400; t++) begin
            @(negedge clk);
            if (id == 0 ? req0_ready : req1_ready) break;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_checks++;
        if (t == 400) begin n_fail++; $display("FAIL accept_timeout: req%0d not accepted in %0d cycles, expected acceptance", id, t); end
    endtask

    task automatic issue_pair(input int first, input logic [15:0] d0, input logic [15:0] ed0, input logic [3:0] ef0,
                              input logic [15:0] d1, input logic [15:0] ed1, input logic [3:0] ef1, input int lat);
        bit got0 = 0, got1 = 0, both = 0, s0, s1;
        int t;
        if (first == 0) begin push_exp(0, ed0, ef0, lat); push_exp(1, ed1, ef1, lat); end
        else            begin push_exp(1, ed1, ef1, lat); push_exp(0, ed0, ef0, lat); end
        @(posedge clk); #1;
        req0_data = d0; req1_data = d1; req0_valid = 1'b1; req1_valid = 1'b1;
        for (t = 0; t < 800 && !(got0 && got1); t++) begin
            @(negedge clk);
            s0 = req0_ready; s1 = req1_ready;
            if (s0 && s1) both = 1;
            if (s0 || s1) begin
                @(posedge clk); #1;
                if (s0) begin req0_valid = 1'b0; got0 = 1; end
                if (s1) begin req1_valid = 1'b0; got1 = 1; end
            end
        end
        n_checks++;
        if (!(got0 && got1) || both) begin
            n_fail++; $display("FAIL pair_accept: got0=%b got1=%b both_ready=%b expected 1 1 0", got0, got1, both);
        end
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 600; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) break;
        end
        n_checks++;
        if (t == 600) begin n_fail++; $display("FAIL drain_timeout: %0d responses still pending, expected 0", sb.size()); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0_valid = 1'b1; req0_data = 16'h4400; mock_lat = 1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, sq_enable, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
                               {busy, sq_enable, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
        n_checks++;
        if ({rsp0_data, rsp0_flags, rsp1_data, rsp1_flags} !== 40'h0) begin
            n_fail++; $display("FAIL reset_rsp: got %h expected 0", {rsp0_data, rsp0_flags, rsp1_data, rsp1_flags});
        end
        tb_drive = 1'b1; #1;
        n_checks++;
        if (sq_io_data !== 16'h0000) begin n_fail++; $display("FAIL reset_bus_float: got %h expected 0000", sq_io_data); end
        tb_drive = 1'b0;
        push_exp(0, 16'h4000, 4'b0000, 6);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL first_grant: busy got %b expected 1", busy); end
        req0_valid = 1'b0;
        drain();
    endtask

    task automatic test_single();
        mock_lat = 1;
        issue(0, 16'h4400, 16'h4000, 4'b0000, 6, 1);
        n_checks++;
        if ({sq_enable, sq_io_data} !== {1'b1, 16'h4400}) begin
            n_fail++; $display("FAIL load_bus: got %b/%h expected 1/4400", sq_enable, sq_io_data);
        end
        drain();
        mock_lat = 3;
        issue(1, 16'h4400, 16'h4000, 4'b0000, 8, 1);
        drain();
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0; #3 rst_n = 1'b1;
        mock_lat = 1;
        issue_pair(0, 16'h3C00, 16'h3C00, 4'b0000, 16'h4C00, 16'h4400, 4'b0000, 6);
        drain();
        issue(0, 16'h4400, 16'h4000, 4'b0000, 6, 1);
        drain();
        issue_pair(1, 16'h4400, 16'h4000, 4'b0000, 16'h3C00, 16'h3C00, 4'b0000, 6);
        drain();
    endtask

    task automatic test_flags();
        mock_lat = 2;
        issue(0, 16'hBC00, 16'hFE00, 4'b0001, 7, 1);
        drain();
        issue(1, 16'h7C00, 16'h7C00, 4'b0010, 7, 1);
        drain();
    endtask

    task automatic test_timeout();
        int lows = 0, t;
        mock_lat = 100;
        issue(0, 16'h4C00, 16'h4400, 4'b0000, 105, 1);
        drain();
        mock_never = 1'b1;
        issue(1, 16'h4400, 16'hFE00, 4'b1001, 105, 1);
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (rsp1_valid) break;
            if (sq_enable) lows = 0;
            else           lows++;
        end
        n_checks++;
        if (lows !== 2 || t == 300) begin n_fail++; $display("FAIL gap_cycles: got %0d expected 2", lows); end
        mock_never = 1'b0;
        drain();
    endtask

    task automatic test_back_to_back();
        bit held = 1;
        int t;
        mock_lat = 1; rsp0_ready = 1'b0;
        issue(0, 16'h4400, 16'h4000, 4'b0000, 6, 1);
        push_exp(1, 16'h3C00, 4'b0000, 6);
        req1_data = 16'h3C00; req1_valid = 1'b1;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (rsp0_valid) break;
        end
        repeat (10) begin
            @(negedge clk);
            if (!rsp0_valid || req1_ready || rsp0_data !== 16'h4000) held = 0;
        end
        n_checks++;
        if (!held || t == 50) begin n_fail++; $display("FAIL backpressure_hold: held=%b expected 1", held); end
        @(posedge clk); #1 rsp0_ready = 1'b1;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (req1_ready) break;
        end
        @(posedge clk); #1 req1_valid = 1'b0;
        drain();
        n_checks++;
        if ({rsp0_data, rsp1_data} !== {16'h4000, 16'h3C00}) begin
            n_fail++; $display("FAIL rsp_retained: got %h expected 40003c00", {rsp0_data, rsp1_data});
        end
    endtask

    task automatic test_reset_mid();
        bit saw = 0;
        mock_never = 1'b1;
        issue(0, 16'h3C00, 16'h0000, 4'b0000, 0, 0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sq_enable, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_mid_enable: got %b expected 00", {sq_enable, busy}); end
        tb_drive = 1'b1; #1;
        n_checks++;
        if (sq_io_data !== 16'h0000) begin n_fail++; $display("FAIL reset_mid_bus: got %h expected 0000", sq_io_data); end
        tb_drive = 1'b0;
        n_checks++;
        if (rsp0_data !== 16'h0000) begin n_fail++; $display("FAIL reset_mid_rsp: got %h expected 0000", rsp0_data); end
        acc_q.delete();
        @(posedge clk); #1 rst_n = 1'b1; mock_never = 1'b0;
        repeat (120) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || busy) saw = 1;
        end
        n_checks++;
        if (saw) begin n_fail++; $display("FAIL reset_mid_no_rsp: activity=%b expected 0", saw); end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_round_robin();
        test_flags();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
